// File: rtl/ti_interp_pkg.sv
// ---------------------------------------------------------------------------
// ti_interp_pkg
// Shared definitions for the 8-lane polyphase I/Q interpolator:
//   - state_e    : priming state (EMPTY = no previous sample, RUN = primed)
//   - W_NEW/W_OLD: per-lane weights, index 0..7 maps to lanes OUT1..OUT8
//   - lane_is_i  : lane-to-component map (lanes 1,3,5,7 carry I; 2,4,6,8 carry Q)
// ---------------------------------------------------------------------------
package ti_interp_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int NUM_LANES = 8;

  // Lane k (1-based) uses phase k/8: the new sample weight grows with k,
  // the old sample weight is the complement so every lane sums to 8.
  localparam int W_NEW [NUM_LANES] = '{1, 2, 3, 4, 5, 6, 7, 8};
  localparam int W_OLD [NUM_LANES] = '{7, 6, 5, 4, 3, 2, 1, 0};

  // Index is 0-based, so even indices are the odd-numbered (I) lanes.
  function automatic bit lane_is_i(input int idx);
    return ((idx % 2) == 0);
  endfunction

endpackage

// File: rtl/ti_interp_lane.sv
// ---------------------------------------------------------------------------
// ti_interp_lane
// Combinational arithmetic for one output lane:
//   acc  = NEW_WEIGHT*new_smp + OLD_WEIGHT*old_smp   (IN_BW+4 bits, signed)
//   r    = (acc + 2^(SHIFT-1)) >>> SHIFT              (round half up)
//   lane = r saturated to OUT_BW bits when TI_POLYPHASE_INTERP_SAT_EN is
//          defined, otherwise r wrapped to its low OUT_BW bits.
// Ports:
//   new_smp : signed IN_BW   newest sample of this lane's component
//   old_smp : signed IN_BW   previous sample of this lane's component
//   lane    : signed OUT_BW  narrowed lane value (unregistered)
// Configuration macro: TI_POLYPHASE_INTERP_SAT_EN
// ---------------------------------------------------------------------------
module ti_interp_lane #(
  parameter int IN_BW      = 11,
  parameter int OUT_BW     = 6,
  parameter int SHIFT      = 8,
  parameter int NEW_WEIGHT = 1,
  parameter int OLD_WEIGHT = 7
) (
  input  logic signed [IN_BW-1:0]  new_smp,
  input  logic signed [IN_BW-1:0]  old_smp,
  output logic signed [OUT_BW-1:0] lane
);

  // Weights sum to 8, so 4 extra bits hold the weighted sum with headroom
  // left for the rounding constant.
  localparam int ACC_W = IN_BW + 4;

  localparam logic signed [ACC_W-1:0] W_NEW_C = ACC_W'(NEW_WEIGHT);
  localparam logic signed [ACC_W-1:0] W_OLD_C = ACC_W'(OLD_WEIGHT);
  localparam logic signed [ACC_W-1:0] RND_C   = ACC_W'(2 ** (SHIFT - 1));
  localparam logic signed [ACC_W-1:0] MAX_C   = ACC_W'((2 ** (OUT_BW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_C   = ACC_W'(-(2 ** (OUT_BW - 1)));

  logic signed [ACC_W-1:0] new_ext_s;
  logic signed [ACC_W-1:0] old_ext_s;
  logic signed [ACC_W-1:0] acc_s;
  logic signed [ACC_W-1:0] rnd_s;
  logic signed [ACC_W-1:0] shr_s;

  // Signed casts sign-extend the samples to the accumulator width.
  assign new_ext_s = ACC_W'(new_smp);
  assign old_ext_s = ACC_W'(old_smp);

  // Weighted sum, rounding offset and arithmetic shift.
  always_comb begin
    acc_s = (new_ext_s * W_NEW_C) + (old_ext_s * W_OLD_C);
    rnd_s = acc_s + RND_C;
    shr_s = rnd_s >>> SHIFT;
  end

`ifdef TI_POLYPHASE_INTERP_SAT_EN
  // Clamp the rounded value into the signed OUT_BW range.
  always_comb begin
    if (shr_s > MAX_C) begin
      lane = OUT_BW'(MAX_C);
    end else if (shr_s < MIN_C) begin
      lane = OUT_BW'(MIN_C);
    end else begin
      lane = OUT_BW'(shr_s);
    end
  end
`else
  // Keep only the low OUT_BW bits (two's-complement wrap).
  always_comb begin
    lane = OUT_BW'(shr_s);
  end
`endif

endmodule

// File: rtl/ti_polyphase_interp8x2.sv
// ---------------------------------------------------------------------------
// ti_polyphase_interp8x2
// Transmit-side polyphase linear interpolator: each accepted I/Q pair is
// blended with the previous pair into 8 time-ordered lanes (odd lanes I at
// phases 1/8..7/8, even lanes Q at phases 2/8..8/8).
// Ports:
//   CLK        in   1       clock
//   RES        in   1       synchronous active-high reset
//   IN_VALID   in   1       IN_I/IN_Q carry a new sample
//   IN_I/IN_Q  in   IN_BW   signed I/Q samples
//   OUT_VALID  out  1       OUT1..OUT8 carry a new 8-lane word
//   OUT1..OUT8 out  OUT_BW  signed lanes, time order 1..8
//   PRIMED     out  1       high while in RUN
//   UFLOW_CNT  out  8       saturating count of idle cycles spent in RUN
// Configuration macro: TI_POLYPHASE_INTERP_SAT_EN (saturate instead of wrap)
// ---------------------------------------------------------------------------
module ti_polyphase_interp8x2
  import ti_interp_pkg::*;
#(
  parameter int IN_BW   = 11,
  parameter int OUT_BW  = 6,
  parameter int SHIFT   = 8,
  parameter int GAP_MAX = 4
) (
  input  logic                     CLK,
  input  logic                     RES,
  input  logic                     IN_VALID,
  input  logic signed [IN_BW-1:0]  IN_I,
  input  logic signed [IN_BW-1:0]  IN_Q,
  output logic                     OUT_VALID,
  output logic signed [OUT_BW-1:0] OUT1,
  output logic signed [OUT_BW-1:0] OUT2,
  output logic signed [OUT_BW-1:0] OUT3,
  output logic signed [OUT_BW-1:0] OUT4,
  output logic signed [OUT_BW-1:0] OUT5,
  output logic signed [OUT_BW-1:0] OUT6,
  output logic signed [OUT_BW-1:0] OUT7,
  output logic signed [OUT_BW-1:0] OUT8,
  output logic                     PRIMED,
  output logic [7:0]               UFLOW_CNT
);

  localparam int GAP_W = $clog2(GAP_MAX + 1);

  state_e                    state_r;
  state_e                    state_nxt_s;
  logic signed [IN_BW-1:0]   old_i_r;
  logic signed [IN_BW-1:0]   old_q_r;
  logic [GAP_W-1:0]          gap_r;
  logic [7:0]                uflow_r;
  logic                      out_valid_r;
  logic signed [OUT_BW-1:0]  out_r  [NUM_LANES];
  logic signed [OUT_BW-1:0]  lane_s [NUM_LANES];

  logic gap_last_s;
  logic load_old_s;
  logic emit_s;
  logic idle_s;

  // This idle cycle would be the GAP_MAX-th in a row.
  assign gap_last_s = (gap_r == GAP_W'(GAP_MAX - 1));

  // State register.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: first sample primes, a long idle gap un-primes.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (IN_VALID) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      RUN: begin
        if (!IN_VALID && gap_last_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Datapath controls decoded from state and IN_VALID.
  always_comb begin
    load_old_s = 1'b0;
    emit_s     = 1'b0;
    idle_s     = 1'b0;
    case (state_r)
      EMPTY: begin
        load_old_s = IN_VALID;
      end
      RUN: begin
        if (IN_VALID) begin
          load_old_s = 1'b1;
          emit_s     = 1'b1;
        end else begin
          idle_s     = 1'b1;
        end
      end
      default: begin
        load_old_s = 1'b0;
      end
    endcase
  end

  // Eight lane engines; odd lanes (even index) use I, even lanes use Q.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic signed [IN_BW-1:0] new_s;
    logic signed [IN_BW-1:0] old_s;

    if (lane_is_i(g)) begin : g_i
      assign new_s = IN_I;
      assign old_s = old_i_r;
    end else begin : g_q
      assign new_s = IN_Q;
      assign old_s = old_q_r;
    end

    ti_interp_lane #(
      .IN_BW      (IN_BW),
      .OUT_BW     (OUT_BW),
      .SHIFT      (SHIFT),
      .NEW_WEIGHT (W_NEW[g]),
      .OLD_WEIGHT (W_OLD[g])
    ) u_lane (
      .new_smp (new_s),
      .old_smp (old_s),
      .lane    (lane_s[g])
    );
  end

  // Sample history, gap tracking, underflow count and lane output registers.
  // The history survives a return to EMPTY but is overwritten by the
  // priming sample before it is ever used again.
  always_ff @(posedge CLK) begin
    if (RES) begin
      old_i_r     <= '0;
      old_q_r     <= '0;
      gap_r       <= '0;
      uflow_r     <= 8'd0;
      out_valid_r <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        out_r[k] <= '0;
      end
    end else begin
      if (load_old_s) begin
        old_i_r <= IN_I;
        old_q_r <= IN_Q;
      end
      out_valid_r <= emit_s;
      if (emit_s) begin
        for (int k = 0; k < NUM_LANES; k++) begin
          out_r[k] <= lane_s[k];
        end
      end
      if (emit_s) begin
        gap_r <= '0;
      end else if (idle_s) begin
        if (gap_last_s) begin
          gap_r <= '0;
        end else begin
          gap_r <= gap_r + GAP_W'(1);
        end
      end
      if (idle_s && (uflow_r != 8'hFF)) begin
        uflow_r <= uflow_r + 8'd1;
      end
    end
  end

  assign OUT_VALID = out_valid_r;
  assign PRIMED    = (state_r == RUN);
  assign UFLOW_CNT = uflow_r;
  assign OUT1      = out_r[0];
  assign OUT2      = out_r[1];
  assign OUT3      = out_r[2];
  assign OUT4      = out_r[3];
  assign OUT5      = out_r[4];
  assign OUT6      = out_r[5];
  assign OUT7      = out_r[6];
  assign OUT8      = out_r[7];

endmodule
